// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset vector, fetch FSM encodings and the
// fetch-to-decode bus layout.
package cpu_defs;

  localparam logic [31:0] RESET_PC        = 32'h1c000000;
  localparam logic [31:0] PC_INC          = 32'd4;
  localparam int          FS_TO_DS_BUS_WD = 65;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fs_state_e;

  // pc + inst + adef, 65 bits total
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fs_bus_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and hands
// one instruction at a time to decode, with a one-entry buffer for stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef,
  input  logic        br_redirect,
  input  logic [31:0] br_target
);
  import cpu_defs::*;

  fs_state_e   state_reg;
  logic [31:0] req_pc_reg;
  logic [31:0] addr_reg;
  fs_bus_t     buf_reg;

  fs_bus_t     wait_bus;
  fs_bus_t     cur_bus;
  logic        valid_next;
  logic        issue;
  logic [31:0] issue_pc;

  // Word arriving from SRAM this cycle; a flagged word is forced to zero.
  always_comb begin
    wait_bus.pc   = req_pc_reg;
    wait_bus.adef = misaligned(req_pc_reg);
    wait_bus.inst = wait_bus.adef ? 32'd0 : inst_sram_rdata;
  end

  always_comb begin
    cur_bus    = '0;
    valid_next = 1'b0;
    issue      = 1'b0;
    issue_pc   = req_pc_reg;
    case (state_reg)
      IDLE: begin
        issue    = 1'b1;
        issue_pc = req_pc_reg;
      end
      WAIT: begin
        cur_bus    = wait_bus;
        valid_next = ~br_redirect;
        if (br_redirect) begin
          issue    = 1'b1;
          issue_pc = br_target;
        end else if (ds_allowin) begin
          issue    = 1'b1;
          issue_pc = req_pc_reg + PC_INC;
        end
      end
      HOLD: begin
        cur_bus    = buf_reg;
        valid_next = ~br_redirect;
        if (br_redirect) begin
          issue    = 1'b1;
          issue_pc = br_target;
        end else if (ds_allowin) begin
          issue    = 1'b1;
          issue_pc = buf_reg.pc + PC_INC;
        end
      end
      default: ;
    endcase
  end

  // Reset squashes any presentation so nothing can fire during it.
  assign fs_valid        = valid_next & resetn;
  assign fs_pc           = cur_bus.pc;
  assign fs_inst         = cur_bus.inst;
  assign fs_adef         = cur_bus.adef;

  assign inst_sram_en    = issue;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'd0;
  assign inst_sram_addr  = issue ? word_align(issue_pc) : addr_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      req_pc_reg <= RESET_PC;
      addr_reg   <= word_align(RESET_PC);
      buf_reg    <= '0;
    end else begin
      addr_reg <= inst_sram_addr;
      case (state_reg)
        IDLE: state_reg <= WAIT;
        WAIT: begin
          if (br_redirect) begin
            req_pc_reg <= br_target;
          end else if (ds_allowin) begin
            req_pc_reg <= req_pc_reg + PC_INC;
          end else begin
            buf_reg   <= wait_bus;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (br_redirect) begin
            req_pc_reg <= br_target;
            state_reg  <= WAIT;
          end else if (ds_allowin) begin
            req_pc_reg <= buf_reg.pc + PC_INC;
            state_reg  <= WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: SRAM model, per-cycle output checks and a
// scoreboard of instructions expected to be handed to decode.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h1c000000;

  logic        clk;
  logic        resetn;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;
  logic        br_redirect;
  logic [31:0] br_target;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  fetch_unit #(.RESET_PC(RST)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .ds_allowin      (ds_allowin),
    .fs_valid        (fs_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst),
    .fs_adef         (fs_adef),
    .br_redirect     (br_redirect),
    .br_target       (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9e3779b9;
  endfunction

  initial inst_sram_rdata = 32'd0;
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.adef = (pc[1:0] != 2'b00);
    e.inst = e.adef ? 32'd0 : mem_word({pc[31:2], 2'b00});
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic rn, input logic al, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    resetn      = rn;
    ds_allowin  = al;
    br_redirect = br;
    br_target   = tgt;
    #1;
  endtask

  // Fire monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (fs_valid === 1'b1 && ds_allowin === 1'b1) begin
      exp_t e;
      vec_cnt++;
      assert (sb_q.size() != 0) else begin
        err_cnt++;
        $error("FAIL unexpected_fire: observed fire pc=%h, expected no fire", fs_pc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("fire pc=%h inst=%h adef=%0d", fs_pc, fs_inst, fs_adef);
        chk("fire_pc", fs_pc, e.pc);
        chk("fire_inst", fs_inst, e.inst);
        chk("fire_adef", {31'd0, fs_adef}, {31'd0, e.adef});
      end
    end
  end

  initial begin
    resetn = 1'b0; ds_allowin = 1'b1; br_redirect = 1'b0; br_target = 32'd0;

    // reset state
    cyc(0, 1, 0, 32'd0);
    cyc(0, 1, 0, 32'd0);
    chk("rst_valid", {31'd0, fs_valid}, 32'd0);
    chk("rst_adef", {31'd0, fs_adef}, 32'd0);
    chk("rst_en", {31'd0, inst_sram_en}, 32'd1);
    chk("rst_addr", inst_sram_addr, RST);
    chk("sram_we", {31'd0, inst_sram_we}, 32'd0);
    chk("sram_wdata", inst_sram_wdata, 32'd0);

    // 1: streaming after reset release
    cyc(1, 1, 0, 32'd0);
    chk("t1_addr0", inst_sram_addr, RST);
    chk("t1_valid0", {31'd0, fs_valid}, 32'd0);
    cyc(1, 1, 0, 32'd0); push_exp(RST);
    chk("t1_addr1", inst_sram_addr, RST + 32'd4);
    chk("t1_valid1", {31'd0, fs_valid}, 32'd1);
    chk("t1_pc1", fs_pc, RST);
    chk("t1_inst1", fs_inst, mem_word(RST));
    cyc(1, 1, 0, 32'd0); push_exp(RST + 32'd4);
    chk("t1_addr2", inst_sram_addr, RST + 32'd8);
    chk("t1_pc2", fs_pc, RST + 32'd4);

    // 2: stall three cycles with req_pc=1c000008
    cyc(1, 0, 0, 32'd0);
    chk("t2_pc", fs_pc, RST + 32'd8);
    chk("t2_en", {31'd0, inst_sram_en}, 32'd0);
    chk("t2_addr_hold", inst_sram_addr, RST + 32'd8);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 32'd0);
      chk("t2_hold_en", {31'd0, inst_sram_en}, 32'd0);
      chk("t2_hold_valid", {31'd0, fs_valid}, 32'd1);
      chk("t2_hold_inst", fs_inst, mem_word(RST + 32'd8));
    end
    cyc(1, 1, 0, 32'd0); push_exp(RST + 32'd8);
    chk("t2_resume_en", {31'd0, inst_sram_en}, 32'd1);
    chk("t2_resume_addr", inst_sram_addr, RST + 32'hc);

    // 3: redirect from HOLD
    cyc(1, 0, 0, 32'd0);
    chk("t3_to_hold_pc", fs_pc, RST + 32'hc);
    cyc(1, 0, 1, 32'h1c000100);
    chk("t3_valid", {31'd0, fs_valid}, 32'd0);
    chk("t3_addr", inst_sram_addr, 32'h1c000100);
    cyc(1, 1, 0, 32'd0); push_exp(32'h1c000100);
    chk("t3_pc", fs_pc, 32'h1c000100);
    chk("t3_inst", fs_inst, mem_word(32'h1c000100));
    chk("t3_next_addr", inst_sram_addr, 32'h1c000104);

    // 4: redirect beats allowin in WAIT
    cyc(1, 1, 1, 32'h1c000040);
    chk("t4_valid", {31'd0, fs_valid}, 32'd0);
    chk("t4_addr", inst_sram_addr, 32'h1c000040);
    cyc(1, 1, 0, 32'd0); push_exp(32'h1c000040);
    chk("t4_pc", fs_pc, 32'h1c000040);

    // 5: misaligned target
    cyc(1, 1, 1, 32'h1c000102);
    chk("t5_addr", inst_sram_addr, 32'h1c000100);
    cyc(1, 1, 0, 32'd0); push_exp(32'h1c000102);
    chk("t5_adef", {31'd0, fs_adef}, 32'd1);
    chk("t5_pc", fs_pc, 32'h1c000102);
    chk("t5_inst", fs_inst, 32'd0);
    chk("t5_next_addr", inst_sram_addr, 32'h1c000104);
    cyc(1, 0, 0, 32'd0);
    chk("t5_pc2", fs_pc, 32'h1c000106);
    cyc(1, 0, 0, 32'd0);
    chk("t5_hold_adef", {31'd0, fs_adef}, 32'd1);
    chk("t5_hold_inst", fs_inst, 32'd0);

    // 6: reset while in HOLD (allowin high, must not fire)
    cyc(0, 1, 0, 32'd0);
    chk("t6_rst_valid", {31'd0, fs_valid}, 32'd0);
    cyc(1, 1, 0, 32'd0);
    chk("t6_idle_valid", {31'd0, fs_valid}, 32'd0);
    chk("t6_idle_addr", inst_sram_addr, RST);
    cyc(1, 1, 0, 32'd0); push_exp(RST);
    chk("t6_pc", fs_pc, RST);

    // PC wrap at the top of the address space
    cyc(1, 1, 1, 32'hfffffffc);
    chk("wrap_addr0", inst_sram_addr, 32'hfffffffc);
    cyc(1, 1, 0, 32'd0); push_exp(32'hfffffffc);
    chk("wrap_addr1", inst_sram_addr, 32'd0);
    cyc(1, 1, 0, 32'd0); push_exp(32'd0);
    chk("wrap_pc", fs_pc, 32'd0);
    chk("wrap_addr2", inst_sram_addr, 32'd4);
    cyc(1, 0, 0, 32'd0);
    cyc(1, 0, 0, 32'd0);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the decode/execute core in mycpu_top.
- Owns the PC and drives the instruction SRAM port.
- Presents one instruction at a time to the core through a valid/allowin handshake.
- Holds the fetched word in a one-entry buffer while the core stalls (multi-cycle core accepts roughly one instruction per 3-5 cycles).
- Accepts branch/jump redirects from the core.

Parameters:
RESET_PC, 32'h1c000000, first instruction address fetched after reset.

Ports:
clk  input  1  clock; all state updates on posedge.
resetn  input  1  synchronous active-low reset, sampled on posedge clk.
inst_sram_en  output  1  read enable; SRAM returns the word for inst_sram_addr on the next cycle.
inst_sram_we  output  1  constant 0.
inst_sram_addr  output  32  word-aligned fetch address ({addr[31:2],2'b00}).
inst_sram_wdata  output  32  constant 0.
inst_sram_rdata  input  32  read data, one cycle after an enabled request.
ds_allowin  input  1  core can accept an instruction this cycle.
fs_valid  output  1  fs_pc/fs_inst/fs_adef valid this cycle.
fs_pc  output  32  PC of the presented instruction.
fs_inst  output  32  presented instruction word.
fs_adef  output  1  fs_pc[1:0]!=0 (fetch address error); fs_inst forced to 0.
br_redirect  input  1  one-cycle redirect from core.
br_target  input  32  redirect target, valid with br_redirect.

Behaviour:
Registers:
- state
- req_pc: PC of the request issued last cycle.
- buf_inst, buf_pc, buf_adef: hold buffer.

fire = fs_valid & ds_allowin. A fire in a given cycle hands that cycle's fs_* to the core.

States: IDLE, WAIT (response arriving from SRAM), HOLD (instruction held in buffer).

Reset (resetn=0 at posedge):
- state<=IDLE, req_pc<=RESET_PC, buffer cleared.
- Outputs while in IDLE: fs_valid=0, fs_adef=0, inst_sram_en=1, inst_sram_addr=RESET_PC.

IDLE:
- Unconditionally go to WAIT; the request for RESET_PC is issued this cycle.
- br_redirect is ignored.

WAIT:
- Presented instruction: fs_pc=req_pc, fs_inst=inst_sram_rdata (0 if adef), fs_adef=(req_pc[1:0]!=0).
- fs_valid = ~br_redirect.
- If br_redirect: issue br_target (en=1), req_pc<=br_target, stay in WAIT.
- Else if ds_allowin: issue req_pc+4, req_pc<=req_pc+4, stay in WAIT. Throughput is 1 instruction/cycle.
- Else: latch rdata/req_pc/adef into the buffer, en=0, go to HOLD.

HOLD:
- Presented instruction comes from the buffer; fs_valid = ~br_redirect.
- If br_redirect: discard the buffer, issue br_target, go to WAIT.
- Else if ds_allowin: issue buf_pc+4, go to WAIT.
- Else: en=0, stay in HOLD; SRAM outputs are ignored.

Rules:
- br_redirect has priority over ds_allowin in the same cycle. The presented (wrong-path) instruction is squashed, so no fire occurs.
- PC arithmetic is 32-bit modulo 2^32; 0xfffffffc+4 wraps to 0.
- A misaligned target is still fetched at the aligned address. The adef flag travels with the instruction and the flagged word is delivered as 0.
- When en=0, inst_sram_addr holds its previous value.
- Reset asserted in any state overrides everything: the next cycle is IDLE, with no fire and no SRAM write.

Decomposition:
- Shared package (cpu_defs): RESET_PC constant, fetch state encodings (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2), PC_INC=32'd4, the fs-to-ds bus width (65 = pc+inst+adef).
- Single flat module; no sub-module needed. The hold buffer is three registers.

Test Plan:
1. Release reset with ds_allowin=1 held: inst_sram_addr sequence is 1c000000, 1c000004, 1c000008. fs_pc lags the address by 1 cycle, fs_inst equals the memory words, fs_valid=1 from cycle 2.
2. In WAIT with req_pc=1c000008, drop ds_allowin for 3 cycles: HOLD is entered, en=0, fs_inst stays mem[1c000008]. On ds_allowin=1, the next address issued is 1c00000c.
3. In HOLD, pulse br_redirect with target 1c000100: fs_valid=0 that cycle. The next cycle shows fs_pc=1c000100 with the correct word.
4. br_redirect and ds_allowin both high in WAIT (target 1c000040): no fire, and the next fs_pc is 1c000040, not req_pc+4.
5. Redirect to 1c000102: inst_sram_addr=1c000100, then fs_adef=1, fs_pc=1c000102, fs_inst=0.
6. Assert resetn=0 for one cycle while in HOLD: fs_valid=0 the next cycle (IDLE), addr=1c000000, and fs_pc=1c000000 one cycle later.
